// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding memory port between the fetch (imem) and load/store (dmem) sides.
// dmem has priority; imem wins after MAX_SKIP consecutive dmem grants while it waits.
module mem_port_arbiter #(
  parameter int MAX_SKIP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  localparam int SW = $clog2(MAX_SKIP + 1);
  localparam logic [SW-1:0] SKIP_LIMIT = SW'(MAX_SKIP);

  typedef enum logic [2:0] {IDLE, ISSUE_I, ISSUE_D, WAIT_I, WAIT_D} state_t;

  state_t state, state_next;

  logic          i_pend;
  logic [31:0]   i_addr;
  logic [3:0]    i_rmask;
  logic          d_pend;
  logic [31:0]   d_addr;
  logic [3:0]    d_rmask;
  logic [3:0]    d_wmask;
  logic [31:0]   d_wdata;
  logic [SW-1:0] skip_cnt, skip_next;

  logic i_req, d_req, i_busy, d_busy;
  logic i_accept, d_accept, i_eff, d_eff;
  logic grant_ok, grant_i, grant_d;

  // A request arriving this cycle counts as valid for a grant at this edge,
  // which gives the one-cycle issue latency and bubble-free back-to-back issue.
  always_comb begin
    imem_resp  = !rst && mem_resp && (state == WAIT_I);
    dmem_resp  = !rst && mem_resp && (state == WAIT_D);
    imem_rdata = imem_resp ? mem_rdata : 32'h0;
    dmem_rdata = dmem_resp ? mem_rdata : 32'h0;

    i_req  = |imem_rmask;
    d_req  = |dmem_rmask || |dmem_wmask;
    i_busy = i_pend || (state == ISSUE_I) || (state == WAIT_I);
    d_busy = d_pend || (state == ISSUE_D) || (state == WAIT_D);

    i_accept = i_req && (!i_busy || imem_resp);
    d_accept = d_req && (!d_busy || dmem_resp);
    i_eff    = i_pend || i_accept;
    d_eff    = d_pend || d_accept;

    grant_ok = (state == IDLE) ||
               (((state == WAIT_I) || (state == WAIT_D)) && mem_resp);
    grant_i  = grant_ok && i_eff && (!d_eff || (skip_cnt == SKIP_LIMIT));
    grant_d  = grant_ok && d_eff && !grant_i;

    state_next = state;
    case (state)
      IDLE, WAIT_I, WAIT_D: begin
        if (grant_i)
          state_next = ISSUE_I;
        else if (grant_d)
          state_next = ISSUE_D;
        else if (state != IDLE && mem_resp)
          state_next = IDLE;
      end
      ISSUE_I: state_next = WAIT_I;
      ISSUE_D: state_next = WAIT_D;
      default: state_next = IDLE;
    endcase

    skip_next = skip_cnt;
    if (grant_i || !i_eff)
      skip_next = '0;
    else if (grant_d && (skip_cnt != SKIP_LIMIT))
      skip_next = skip_cnt + 1'b1;
  end

  // Masks are registered for exactly one cycle per grant; address and data
  // stay in place until the next grant, which covers the whole transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      skip_cnt  <= '0;
      i_pend    <= 1'b0;
      i_addr    <= 32'h0;
      i_rmask   <= 4'h0;
      d_pend    <= 1'b0;
      d_addr    <= 32'h0;
      d_rmask   <= 4'h0;
      d_wmask   <= 4'h0;
      d_wdata   <= 32'h0;
      mem_addr  <= 32'h0;
      mem_rmask <= 4'h0;
      mem_wmask <= 4'h0;
      mem_wdata <= 32'h0;
    end else begin
      state     <= state_next;
      skip_cnt  <= skip_next;
      mem_rmask <= 4'h0;
      mem_wmask <= 4'h0;

      if (grant_i) begin
        mem_addr  <= i_pend ? i_addr  : imem_addr;
        mem_rmask <= i_pend ? i_rmask : imem_rmask;
        mem_wdata <= 32'h0;
        i_pend    <= 1'b0;
      end else if (i_accept) begin
        i_pend  <= 1'b1;
        i_addr  <= imem_addr;
        i_rmask <= imem_rmask;
      end

      if (grant_d) begin
        mem_addr  <= d_pend ? d_addr  : dmem_addr;
        mem_rmask <= d_pend ? d_rmask : dmem_rmask;
        mem_wmask <= d_pend ? d_wmask : dmem_wmask;
        mem_wdata <= d_pend ? d_wdata : dmem_wdata;
        d_pend    <= 1'b0;
      end else if (d_accept) begin
        d_pend  <= 1'b1;
        d_addr  <= dmem_addr;
        d_rmask <= dmem_rmask;
        d_wmask <= dmem_wmask;
        d_wdata <= dmem_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: lone fetch, collision, buffered store,
// starvation bound, reset mid-transaction and same-cycle re-request.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.MAX_SKIP(4)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic applyStimulus(input logic [3:0] i_rm, input logic [31:0] i_ad,
                               input logic [3:0] d_rm, input logic [3:0] d_wm,
                               input logic [31:0] d_ad, input logic [31:0] d_wd,
                               input logic m_rsp, input logic [31:0] m_rd);
    imem_rmask = i_rm;
    imem_addr  = i_ad;
    dmem_rmask = d_rm;
    dmem_wmask = d_wm;
    dmem_addr  = d_ad;
    dmem_wdata = d_wd;
    mem_resp   = m_rsp;
    mem_rdata  = m_rd;
    #1;
  endtask

  task automatic idle();
    applyStimulus(4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkIssue(input string tag, input logic [31:0] addr,
                            input logic [3:0] rmask, input logic [3:0] wmask);
    checkOutput({tag, " addr"}, mem_addr, addr);
    checkOutput({tag, " rmask"}, {28'h0, mem_rmask}, {28'h0, rmask});
    checkOutput({tag, " wmask"}, {28'h0, mem_wmask}, {28'h0, wmask});
  endtask

  task automatic checkResp(input string tag, input logic ir, input logic [31:0] ird,
                           input logic dr, input logic [31:0] drd);
    checkOutput({tag, " imem_resp"}, {31'h0, imem_resp}, {31'h0, ir});
    checkOutput({tag, " imem_rdata"}, imem_rdata, ird);
    checkOutput({tag, " dmem_resp"}, {31'h0, dmem_resp}, {31'h0, dr});
    checkOutput({tag, " dmem_rdata"}, dmem_rdata, drd);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    // Reset state
    checkIssue("reset", 32'h0, 4'h0, 4'h0);
    checkOutput("reset wdata", mem_wdata, 32'h0);
    checkResp("reset", 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;
    tick();

    $display("[TB] lone fetch");
    applyStimulus(4'hF, 32'h6000_0000, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("t1 c0 rmask", {28'h0, mem_rmask}, 32'h0);
    tick(); idle();
    checkIssue("t1 c1", 32'h6000_0000, 4'hF, 4'h0);
    tick(); idle();
    checkIssue("t1 c2", 32'h6000_0000, 4'h0, 4'h0);
    tick();
    applyStimulus(4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0000_0013);
    checkResp("t1 c3", 1'b1, 32'h13, 1'b0, 32'h0);
    checkOutput("t1 c3 addr", mem_addr, 32'h6000_0000);
    tick(); idle();
    checkResp("t1 c4", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();

    $display("[TB] collision");
    applyStimulus(4'hF, 32'h200, 4'hF, 4'h0, 32'h100, 32'h0, 1'b0, 32'h0);
    tick(); idle();
    checkIssue("t2 dmem issue", 32'h100, 4'hF, 4'h0);
    tick(); idle();
    checkIssue("t2 dmem hold", 32'h100, 4'h0, 4'h0);
    tick();
    applyStimulus(4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'hAAAA_0001);
    checkResp("t2 dmem resp", 1'b0, 32'h0, 1'b1, 32'hAAAA_0001);
    tick(); idle();
    checkIssue("t2 imem issue", 32'h200, 4'hF, 4'h0);
    tick(); idle();
    checkIssue("t2 imem hold", 32'h200, 4'h0, 4'h0);
    tick();
    applyStimulus(4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h5555_0002);
    checkResp("t2 imem resp", 1'b1, 32'h5555_0002, 1'b0, 32'h0);
    checkOutput("t2 imem resp addr", mem_addr, 32'h200);
    tick(); idle();
    tick();

    $display("[TB] store during fetch");
    applyStimulus(4'hF, 32'h300, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick(); idle();
    checkIssue("t3 fetch issue", 32'h300, 4'hF, 4'h0);
    tick();
    applyStimulus(4'h0, 32'h0, 4'h0, 4'h3, 32'h400, 32'h0000_BEEF, 1'b0, 32'h0);
    checkIssue("t3 store buffered", 32'h300, 4'h0, 4'h0);
    tick(); idle();
    checkIssue("t3 wait", 32'h300, 4'h0, 4'h0);
    applyStimulus(4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h77);
    checkResp("t3 fetch resp", 1'b1, 32'h77, 1'b0, 32'h0);
    tick(); idle();
    checkIssue("t3 store issue", 32'h400, 4'h0, 4'h3);
    checkOutput("t3 store wdata", mem_wdata, 32'h0000_BEEF);
    tick(); idle();
    checkOutput("t3 wdata hold", mem_wdata, 32'h0000_BEEF);
    applyStimulus(4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0);
    checkResp("t3 store resp", 1'b0, 32'h0, 1'b1, 32'h0);
    checkOutput("t3 resp wdata", mem_wdata, 32'h0000_BEEF);
    tick(); idle();
    tick();

    $display("[TB] starvation bound");
    applyStimulus(4'hF, 32'h500, 4'hF, 4'h0, 32'h600, 32'h0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick(); idle();
      checkIssue($sformatf("t4 dmem grant %0d", k), 32'h600 + 32'(4 * k), 4'hF, 4'h0);
      tick();
      applyStimulus(4'h0, 32'h0, 4'hF, 4'h0, 32'h600 + 32'(4 * (k + 1)), 32'h0,
                    1'b1, 32'h1000 + 32'(k));
      checkResp($sformatf("t4 dmem resp %0d", k), 1'b0, 32'h0, 1'b1, 32'h1000 + 32'(k));
    end
    tick(); idle();
    checkIssue("t4 imem grant", 32'h500, 4'hF, 4'h0);
    tick();
    applyStimulus(4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h2000);
    checkResp("t4 imem resp", 1'b1, 32'h2000, 1'b0, 32'h0);
    tick(); idle();
    checkIssue("t4 last dmem", 32'h610, 4'hF, 4'h0);
    tick();
    applyStimulus(4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h3000);
    checkResp("t4 last resp", 1'b0, 32'h0, 1'b1, 32'h3000);
    tick(); idle();
    tick();

    $display("[TB] reset mid-transaction");
    applyStimulus(4'h0, 32'h0, 4'hF, 4'h0, 32'h700, 32'h0, 1'b0, 32'h0);
    tick(); idle();
    checkIssue("t5 issue", 32'h700, 4'hF, 4'h0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkIssue("t5 after reset", 32'h0, 4'h0, 4'h0);
    tick();
    applyStimulus(4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    checkResp("t5 stray resp", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    applyStimulus(4'h0, 32'h0, 4'hF, 4'h0, 32'h800, 32'h0, 1'b0, 32'h0);
    tick(); idle();
    checkIssue("t5 new issue", 32'h800, 4'hF, 4'h0);
    tick();
    applyStimulus(4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h88);
    checkResp("t5 new resp", 1'b0, 32'h0, 1'b1, 32'h88);
    tick(); idle();
    tick();

    $display("[TB] same-cycle re-request");
    applyStimulus(4'hF, 32'h900, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick(); idle();
    checkIssue("t6 first issue", 32'h900, 4'hF, 4'h0);
    tick(); idle();
    tick();
    applyStimulus(4'hF, 32'h904, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h99);
    checkResp("t6 first resp", 1'b1, 32'h99, 1'b0, 32'h0);
    tick(); idle();
    checkIssue("t6 second issue", 32'h904, 4'hF, 4'h0);
    tick(); idle();
    tick();
    applyStimulus(4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h9A);
    checkResp("t6 second resp", 1'b1, 32'h9A, 1'b0, 32'h0);
    tick(); idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
